// File: rtl/dcache_pkg.sv
// Shared FSM encoding and address-field width helpers
// for the set-associative data cache.
package dcache_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WRITEBACK,
    S_ALLOCATE,
    S_REFILL
  } state_e;

  function automatic int off_w(input int line_w);
    return $clog2(line_w / 8);
  endfunction

  function automatic int idx_w(input int sets);
    return $clog2(sets);
  endfunction

  function automatic int tag_w(
    input int addr_w,
    input int line_w,
    input int sets
  );
    return addr_w - off_w(line_w) - idx_w(sets);
  endfunction

  function automatic int wsel_lo(input int data_w);
    return $clog2(data_w / 8);
  endfunction

  function automatic int way_w(input int ways);
    return (ways > 1) ? $clog2(ways) : 1;
  endfunction

endpackage

// File: rtl/dcache_assoc_sram.sv
// Tag/valid/dirty/data storage with combinational hit
// detection and a victim read port.
module dcache_assoc_sram
  import dcache_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int LINE_W = 256,
  parameter int SETS   = 16,
  parameter int WAYS   = 2,
  parameter int TAG_W  = 23,
  localparam int IDX_W  = idx_w(SETS),
  localparam int WAY_W  = way_w(WAYS),
  localparam int WSEL_W = $clog2(LINE_W / DATA_W)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [IDX_W-1:0]  idx_i,
  input  logic [TAG_W-1:0]  tag_i,
  output logic              hit_o,
  output logic [WAY_W-1:0]  hit_way_o,
  output logic [LINE_W-1:0] hit_line_o,
  output logic [WAYS-1:0]   valid_o,
  output logic [WAYS-1:0]   dirty_o,
  input  logic [WAY_W-1:0]  rd_way_i,
  output logic [TAG_W-1:0]  rd_tag_o,
  output logic [LINE_W-1:0] rd_line_o,
  input  logic              fill_i,
  input  logic [LINE_W-1:0] fill_line_i,
  input  logic              wr_i,
  input  logic [WAY_W-1:0]  wr_way_i,
  input  logic [WSEL_W-1:0] wsel_i,
  input  logic [DATA_W-1:0] wdata_i
);

  logic [TAG_W-1:0]  tag_q  [SETS][WAYS];
  logic [LINE_W-1:0] line_q [SETS][WAYS];
  logic [SETS-1:0][WAYS-1:0] valid_q;
  logic [SETS-1:0][WAYS-1:0] dirty_q;

  assign valid_o = valid_q[idx_i];
  assign dirty_o = dirty_q[idx_i];

  always_comb begin
    hit_o     = 1'b0;
    hit_way_o = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (valid_q[idx_i][w] &&
          tag_q[idx_i][w] == tag_i) begin
        hit_o     = 1'b1;
        hit_way_o = WAY_W'(w);
      end
    end
  end

  assign hit_line_o = line_q[idx_i][hit_way_o];
  assign rd_tag_o   = tag_q[idx_i][rd_way_i];
  assign rd_line_o  = line_q[idx_i][rd_way_i];

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else if (fill_i) begin
      valid_q[idx_i][wr_way_i] <= 1'b1;
      dirty_q[idx_i][wr_way_i] <= 1'b0;
    end else if (wr_i) begin
      dirty_q[idx_i][wr_way_i] <= 1'b1;
    end
  end

  // Payload arrays are qualified by valid, so they need no reset.
  always_ff @(posedge clk_i) begin
    if (fill_i) begin
      tag_q[idx_i][wr_way_i]  <= tag_i;
      line_q[idx_i][wr_way_i] <= fill_line_i;
    end else if (wr_i) begin
      line_q[idx_i][wr_way_i][wsel_i*DATA_W +: DATA_W]
        <= wdata_i;
    end
  end

endmodule

// File: rtl/dcache_assoc_ctrl.sv
// Write-back, write-allocate set-associative data cache
// controller with round-robin replacement and hit/miss counters.
module dcache_assoc_ctrl
  import dcache_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int LINE_W = 256,
  parameter int SETS   = 16,
  parameter int WAYS   = 2
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [ADDR_W-1:0] cpu_addr_i,
  input  logic [DATA_W-1:0] cpu_data_i,
  input  logic              cpu_MemRead_i,
  input  logic              cpu_MemWrite_i,
  output logic [DATA_W-1:0] cpu_data_o,
  output logic              cpu_stall_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [LINE_W-1:0] mem_data_o,
  output logic              mem_enable_o,
  output logic              mem_write_o,
  input  logic [LINE_W-1:0] mem_data_i,
  input  logic              mem_ack_i,
  output logic [31:0]       hit_cnt_o,
  output logic [31:0]       miss_cnt_o
);

  localparam int OFF_W   = off_w(LINE_W);
  localparam int IDX_W   = idx_w(SETS);
  localparam int TAG_W   = tag_w(ADDR_W, LINE_W, SETS);
  localparam int WAY_W   = way_w(WAYS);
  localparam int WSEL_LO = wsel_lo(DATA_W);
  localparam int WSEL_W  = OFF_W - WSEL_LO;

  state_e state_q, state_d;
  logic [TAG_W-1:0]  req_tag_q, req_tag_d;
  logic [IDX_W-1:0]  req_idx_q, req_idx_d;
  logic [WAY_W-1:0]  vic_way_q, vic_way_d;
  logic [LINE_W-1:0] fill_line_q, fill_line_d;
  logic              retry_q, retry_d;
  logic [SETS-1:0][WAY_W-1:0] rr_q, rr_d;
  logic [31:0] hit_cnt_q, hit_cnt_d;
  logic [31:0] miss_cnt_q, miss_cnt_d;

  logic [TAG_W-1:0]  cpu_tag, sram_tag, rd_tag;
  logic [IDX_W-1:0]  cpu_idx, sram_idx;
  logic [WSEL_W-1:0] cpu_wsel;
  logic [WAY_W-1:0]  hit_way, vic_sel, wr_way;
  logic [LINE_W-1:0] hit_line, rd_line;
  logic [WAYS-1:0]   valid, dirty;
  logic [DATA_W-1:0] rdata;
  logic idle, req, hit, stall, wr, fill;
  logic hit_inc, miss_inc;
  logic unused_lsb;

  assign cpu_tag  = cpu_addr_i[ADDR_W-1 -: TAG_W];
  assign cpu_idx  = cpu_addr_i[OFF_W +: IDX_W];
  assign cpu_wsel = cpu_addr_i[WSEL_LO +: WSEL_W];
  assign unused_lsb = ^cpu_addr_i[WSEL_LO-1:0];

  assign idle     = (state_q == S_IDLE);
  assign req      = cpu_MemRead_i | cpu_MemWrite_i;
  assign sram_idx = idle ? cpu_idx : req_idx_q;
  assign sram_tag = idle ? cpu_tag : req_tag_q;
  assign wr_way   = fill ? vic_way_q : hit_way;

  dcache_assoc_sram #(
    .DATA_W (DATA_W),
    .LINE_W (LINE_W),
    .SETS   (SETS),
    .WAYS   (WAYS),
    .TAG_W  (TAG_W)
  ) u_sram (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .idx_i       (sram_idx),
    .tag_i       (sram_tag),
    .hit_o       (hit),
    .hit_way_o   (hit_way),
    .hit_line_o  (hit_line),
    .valid_o     (valid),
    .dirty_o     (dirty),
    .rd_way_i    (vic_way_q),
    .rd_tag_o    (rd_tag),
    .rd_line_o   (rd_line),
    .fill_i      (fill),
    .fill_line_i (fill_line_q),
    .wr_i        (wr),
    .wr_way_i    (wr_way),
    .wsel_i      (cpu_wsel),
    .wdata_i     (cpu_data_i)
  );

  // Lowest invalid way wins; otherwise the set's round-robin pointer.
  always_comb begin
    vic_sel = rr_q[sram_idx];
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (!valid[w]) vic_sel = WAY_W'(w);
    end
  end

  always_comb begin
    state_d      = state_q;
    req_tag_d    = req_tag_q;
    req_idx_d    = req_idx_q;
    vic_way_d    = vic_way_q;
    fill_line_d  = fill_line_q;
    retry_d      = retry_q;
    rr_d         = rr_q;
    stall        = 1'b0;
    rdata        = '0;
    wr           = 1'b0;
    fill         = 1'b0;
    hit_inc      = 1'b0;
    miss_inc     = 1'b0;
    mem_enable_o = 1'b0;
    mem_write_o  = 1'b0;
    mem_addr_o   = '0;
    mem_data_o   = '0;
    unique case (state_q)
      S_IDLE: begin
        retry_d = 1'b0;
        if (req && hit) begin
          rdata   = hit_line[cpu_wsel*DATA_W +: DATA_W];
          wr      = cpu_MemWrite_i;
          hit_inc = !retry_q;
        end else if (req) begin
          stall     = 1'b1;
          miss_inc  = 1'b1;
          req_tag_d = cpu_tag;
          req_idx_d = cpu_idx;
          vic_way_d = vic_sel;
          state_d   = (valid[vic_sel] && dirty[vic_sel]) ?
                      S_WRITEBACK : S_ALLOCATE;
        end
      end
      S_WRITEBACK: begin
        stall        = 1'b1;
        mem_enable_o = 1'b1;
        mem_write_o  = 1'b1;
        mem_addr_o   = {rd_tag, req_idx_q, {OFF_W{1'b0}}};
        mem_data_o   = rd_line;
        if (mem_ack_i) state_d = S_ALLOCATE;
      end
      S_ALLOCATE: begin
        stall        = 1'b1;
        mem_enable_o = 1'b1;
        mem_addr_o   = {req_tag_q, req_idx_q, {OFF_W{1'b0}}};
        if (mem_ack_i) begin
          fill_line_d = mem_data_i;
          state_d     = S_REFILL;
        end
      end
      S_REFILL: begin
        stall   = 1'b1;
        fill    = 1'b1;
        retry_d = 1'b1;
        state_d = S_IDLE;
        rr_d[req_idx_q] =
          (rr_q[req_idx_q] == WAY_W'(WAYS - 1)) ?
          '0 : rr_q[req_idx_q] + 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
    hit_cnt_d  = (hit_inc && hit_cnt_q != '1) ?
                 hit_cnt_q + 32'd1 : hit_cnt_q;
    miss_cnt_d = (miss_inc && miss_cnt_q != '1) ?
                 miss_cnt_q + 32'd1 : miss_cnt_q;
  end

  // A pending request must not stall the pipeline while in reset.
  assign cpu_stall_o = rst_i & stall;
  assign cpu_data_o  = rst_i ? rdata : '0;
  assign hit_cnt_o   = hit_cnt_q;
  assign miss_cnt_o  = miss_cnt_q;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q     <= S_IDLE;
      req_tag_q   <= '0;
      req_idx_q   <= '0;
      vic_way_q   <= '0;
      fill_line_q <= '0;
      retry_q     <= 1'b0;
      rr_q        <= '0;
      hit_cnt_q   <= '0;
      miss_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      req_tag_q   <= req_tag_d;
      req_idx_q   <= req_idx_d;
      vic_way_q   <= vic_way_d;
      fill_line_q <= fill_line_d;
      retry_q     <= retry_d;
      rr_q        <= rr_d;
      hit_cnt_q   <= hit_cnt_d;
      miss_cnt_q  <= miss_cnt_d;
    end
  end

endmodule

// File: tb/tb_dcache_assoc_ctrl.sv
// Scoreboard bench: CPU responses and memory transactions
// are queued at issue and checked by separate monitors.
module tb_dcache_assoc_ctrl;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [31:0]  cpu_addr, cpu_wdata, cpu_rdata;
  logic         mem_rd, mem_wr, stall;
  logic [31:0]  mem_addr;
  logic [255:0] mem_wdata, mem_rdata;
  logic         mem_en, mem_we;
  logic         mem_ack_r, spur_ack, mem_ack;
  logic [31:0]  hit_cnt, miss_cnt;

  assign mem_ack = mem_ack_r | spur_ack;

  always #5 clk = ~clk;

  dcache_assoc_ctrl #(
    .ADDR_W (32), .DATA_W (32), .LINE_W (256),
    .SETS   (16), .WAYS   (2)
  ) dut (
    .clk_i          (clk),
    .rst_i          (rst_n),
    .cpu_addr_i     (cpu_addr),
    .cpu_data_i     (cpu_wdata),
    .cpu_MemRead_i  (mem_rd),
    .cpu_MemWrite_i (mem_wr),
    .cpu_data_o     (cpu_rdata),
    .cpu_stall_o    (stall),
    .mem_addr_o     (mem_addr),
    .mem_data_o     (mem_wdata),
    .mem_enable_o   (mem_en),
    .mem_write_o    (mem_we),
    .mem_data_i     (mem_rdata),
    .mem_ack_i      (mem_ack),
    .hit_cnt_o      (hit_cnt),
    .miss_cnt_o     (miss_cnt)
  );

  typedef struct {
    logic        is_load;
    logic [31:0] data;
    int          stalls;
    string       name;
  } cpu_exp_t;

  typedef struct {
    logic         we;
    logic [31:0]  addr;
    logic [255:0] line;
    string        name;
  } mem_exp_t;

  cpu_exp_t cpu_q[$];
  mem_exp_t mem_q[$];
  int n_cmp = 0;
  int n_err = 0;
  int stall_cnt = 0;
  int done_cnt = 0;
  logic mon_en = 1'b0;

  task automatic chk(input string nm,
                     input logic [255:0] act,
                     input logic [255:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic fail(input string nm);
    n_cmp++;
    n_err++;
    $display("FAIL %s", nm);
  endtask

  function automatic logic [255:0] pat(input logic [31:0] la);
    logic [255:0] l;
    for (int i = 0; i < 8; i++)
      l[i*32 +: 32] = 32'hA000_0000 | (la + 32'(i * 4));
    return l;
  endfunction

  task automatic push_mem(input string nm, input logic we,
                          input logic [31:0] a,
                          input logic [255:0] line);
    mem_exp_t e;
    e.we = we; e.addr = a; e.line = line; e.name = nm;
    mem_q.push_back(e);
  endtask

  task automatic access(input string nm,
                        input logic wr, input logic rd,
                        input logic [31:0] a,
                        input logic [31:0] wd,
                        input logic [31:0] ed,
                        input int es);
    cpu_exp_t e;
    int start;
    e.is_load = !wr; e.data = ed; e.stalls = es; e.name = nm;
    cpu_q.push_back(e);
    start = done_cnt;
    cpu_addr = a; cpu_wdata = wd;
    mem_rd = rd; mem_wr = wr; mon_en = 1'b1;
    for (int k = 0; k < 200; k++) begin
      @(posedge clk);
      if (done_cnt != start) break;
    end
    #1;
    if (done_cnt == start) begin
      fail({nm, "_timeout"});
      void'(cpu_q.pop_back());
    end
    mon_en = 1'b0; mem_rd = 1'b0; mem_wr = 1'b0;
  endtask

  // CPU monitor: an access completes on the first unstalled cycle.
  initial begin
    cpu_exp_t me;
    forever begin
      @(negedge clk);
      if (mon_en && stall) begin
        stall_cnt++;
      end else if (mon_en) begin
        if (cpu_q.size() == 0) begin
          fail("cpu_unexpected");
        end else begin
          me = cpu_q.pop_front();
          if (me.is_load)
            chk({me.name, "_data"}, 256'(cpu_rdata), 256'(me.data));
          chk({me.name, "_stalls"}, 256'(stall_cnt), 256'(me.stalls));
        end
        stall_cnt = 0;
        done_cnt++;
        @(posedge clk);
      end
    end
  end

  // Memory model: checks each request, acks 10 cycles after enable.
  initial begin
    mem_exp_t re;
    logic abort;
    logic [31:0] a;
    mem_ack_r = 1'b0;
    mem_rdata = '0;
    forever begin
      @(negedge clk);
      if (mem_en === 1'b1) begin
        a = 32'h0;
        if (mem_q.size() == 0) begin
          fail("mem_unexpected");
        end else begin
          re = mem_q.pop_front();
          a = re.addr;
          chk({re.name, "_we"}, 256'(mem_we), 256'(re.we));
          chk({re.name, "_addr"}, 256'(mem_addr), 256'(re.addr));
          if (re.we) chk({re.name, "_line"}, mem_wdata, re.line);
        end
        abort = 1'b0;
        for (int i = 0; i < 10; i++) begin
          @(posedge clk); #1;
          if (mem_en !== 1'b1) begin abort = 1'b1; break; end
        end
        if (!abort) begin
          mem_rdata = pat(a);
          mem_ack_r = 1'b1;
          @(posedge clk); #1;
          mem_ack_r = 1'b0;
        end
      end
    end
  end

  initial begin
    #300000;
    fail("watchdog");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [255:0] wb_line;
    rst_n = 1'b0; spur_ack = 1'b0;
    cpu_addr = 32'h100; cpu_wdata = '0;
    mem_rd = 1'b1; mem_wr = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_stall", 256'(stall), 256'(0));
    chk("rst_rdata", 256'(cpu_rdata), 256'(0));
    chk("rst_en", 256'(mem_en), 256'(0));
    chk("rst_we", 256'(mem_we), 256'(0));
    chk("rst_addr", 256'(mem_addr), 256'(0));
    chk("rst_wdata", mem_wdata, 256'(0));
    chk("rst_hit", 256'(hit_cnt), 256'(0));
    chk("rst_miss", 256'(miss_cnt), 256'(0));
    mem_rd = 1'b0; rst_n = 1'b1;
    @(posedge clk); #1;

    push_mem("cold_rd", 1'b0, 32'h100, '0);
    access("cold", 1'b0, 1'b1, 32'h100, 0, 32'hA000_0100, 13);
    chk("cold_miss", 256'(miss_cnt), 256'(1));
    chk("cold_hit", 256'(hit_cnt), 256'(0));

    access("st_hit", 1'b1, 1'b0, 32'h104, 32'hDEAD_BEEF, 0, 0);
    chk("st_hit_cnt", 256'(hit_cnt), 256'(1));
    access("ld_hit", 1'b0, 1'b1, 32'h104, 0, 32'hDEAD_BEEF, 0);
    chk("ld_hit_cnt", 256'(hit_cnt), 256'(2));

    push_mem("st_both_rd", 1'b0, 32'h300, '0);
    access("st_both", 1'b1, 1'b1, 32'h300, 32'h1111_2222, 0, 13);
    chk("st_both_miss", 256'(miss_cnt), 256'(2));
    chk("st_both_hit", 256'(hit_cnt), 256'(2));

    wb_line = pat(32'h100);
    wb_line[63:32] = 32'hDEAD_BEEF;
    push_mem("evict_wb", 1'b1, 32'h100, wb_line);
    push_mem("evict_rd", 1'b0, 32'h500, '0);
    access("evict", 1'b0, 1'b1, 32'h500, 0, 32'hA000_0500, 24);
    chk("evict_miss", 256'(miss_cnt), 256'(3));
    access("ld_300", 1'b0, 1'b1, 32'h300, 0, 32'h1111_2222, 0);
    chk("ld_300_hit", 256'(hit_cnt), 256'(3));

    push_mem("rmm_rd", 1'b0, 32'h2040, '0);
    cpu_addr = 32'h2040; mem_rd = 1'b1;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk); #1;
      if (mem_en) break;
    end
    repeat (2) @(posedge clk);
    #1;
    chk("rmm_alloc_en", 256'(mem_en), 256'(1));
    mem_rd = 1'b0; rst_n = 1'b0;
    #1;
    chk("rmm_en", 256'(mem_en), 256'(0));
    chk("rmm_stall", 256'(stall), 256'(0));
    chk("rmm_miss", 256'(miss_cnt), 256'(0));
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    push_mem("rmm_rd2", 1'b0, 32'h2040, '0);
    access("rmm_again", 1'b0, 1'b1, 32'h2040, 0, 32'hA000_2040, 13);
    chk("rmm_again_miss", 256'(miss_cnt), 256'(1));

    spur_ack = 1'b1;
    @(posedge clk); #1;
    spur_ack = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("spur_en", 256'(mem_en), 256'(0));
    chk("spur_hit", 256'(hit_cnt), 256'(0));
    chk("spur_miss", 256'(miss_cnt), 256'(1));
    access("spur_ld", 1'b0, 1'b1, 32'h2044, 0, 32'hA000_2044, 0);
    chk("spur_ld_hit", 256'(hit_cnt), 256'(1));

    push_mem("drop_rd", 1'b0, 32'h3080, '0);
    cpu_addr = 32'h3080; mem_rd = 1'b1;
    repeat (2) @(posedge clk);
    #1 mem_rd = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    chk("drop_miss", 256'(miss_cnt), 256'(2));
    chk("drop_hit", 256'(hit_cnt), 256'(1));
    chk("drop_en", 256'(mem_en), 256'(0));
    access("drop_ld", 1'b0, 1'b1, 32'h3080, 0, 32'hA000_3080, 0);
    chk("drop_ld_hit", 256'(hit_cnt), 256'(2));

    force dut.miss_cnt_q = 32'hFFFF_FFFF;
    @(posedge clk);
    #1 release dut.miss_cnt_q;
    chk("sat_pre", 256'(miss_cnt), 256'(32'hFFFF_FFFF));
    push_mem("sat_rd", 1'b0, 32'h40C0, '0);
    access("sat", 1'b0, 1'b1, 32'h40C4, 0, 32'hA000_40C4, 13);
    chk("sat_miss", 256'(miss_cnt), 256'(32'hFFFF_FFFF));

    repeat (2) @(posedge clk);
    chk("cpu_q_left", 256'(cpu_q.size()), 256'(0));
    chk("mem_q_left", 256'(mem_q.size()), 256'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
